mod_counter_ctrl: RTL and testbench
===================================

// Module: mod_counter_ctrl
//
// PURPOSE
// Run-control sequencer with an embedded programmable modulo counter (BCD-style count,
// modulus 2..MAX_MOD). Accepts a modulus and wrap budget over a valid/ready config port,
// then sequences start/pause/stop of the count and reports wrap events and completion.
// Sits between the control/CSR logic and any digit/display or timing datapath.
//
// PARAMETERS
// WIDTH    4   count width in bits
// MAX_MOD  10  largest legal modulus (10 = BCD digit); reset-default modulus
// WRAP_W   8   width of wrap budget and wrap counter
//
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-low reset
// cfg_valid  in   1       config request
// cfg_ready  out  1       config accepted when cfg_valid & cfg_ready
// cfg_mod    in   WIDTH   requested modulus; legal range 2..MAX_MOD
// cfg_wraps  in   WRAP_W  wraps before DONE; 0 = run continuously
// start      in   1       begin counting (IDLE/DONE only)
// pause      in   1       level: hold count while high (RUN/PAUSE)
// stop       in   1       abort to IDLE from any state
// count      out  WIDTH   current count, 0..mod-1
// tc         out  1       1-cycle pulse in the first cycle count shows 0 after a wrap
// wrap_cnt   out  WRAP_W  wraps completed since last start
// busy       out  1       state is RUN or PAUSE
// done       out  1       state is DONE
// cfg_err    out  1       1-cycle pulse: config handshake with illegal cfg_mod
//
// BEHAVIOUR
// - Reset (reset==0, async, takes effect immediately): state=IDLE, mod_r=MAX_MOD,
//   wraps_r=0, count=0, wrap_cnt=0, tc=0, done=0, busy=0, cfg_err=0, cfg_ready=1.
// - All outputs registered; busy/done/cfg_ready decoded from the state register only.
// - States: IDLE, RUN, PAUSE, DONE. Same-cycle priority: stop > start > pause.
// - cfg_ready=1 in IDLE and DONE only; 0 in RUN/PAUSE (requester holds cfg_valid).
//   Accepted config with 2<=cfg_mod<=MAX_MOD latches mod_r/wraps_r next edge.
//   Otherwise mod_r/wraps_r unchanged and cfg_err=1 for exactly one cycle.
//   Config and start in the same cycle: the new config applies to that run.
// - IDLE/DONE + start: next state RUN, count=0, wrap_cnt=0, done=0. First increment
//   happens on the edge after RUN is entered (count 0 visible for one cycle).
// - RUN, pause=0: each edge count<=count+1; when count==mod_r-1: count<=0, tc<=1,
//   wrap_cnt<=wrap_cnt+1 (mod 2^WRAP_W). If wraps_r!=0 and wrap_cnt+1==wraps_r:
//   next state DONE, count=0, done=1 (tc still pulses on that edge).
// - RUN, pause=1: next state PAUSE, count/wrap_cnt held, no tc.
// - PAUSE: held while pause=1; pause=0 -> RUN, increment resumes on the following edge.
// - DONE: count=0, done=1 until start or stop. start ignored in RUN/PAUSE.
// - stop (any state): next state IDLE, count=0, wrap_cnt=0, tc=0, done=0; config kept.
// - tc=0 on every edge not performing a wrap. wraps_r=0: never DONE; wrap_cnt rolls
//   over from 2^WRAP_W-1 to 0.
//
// TESTING
// 1. cfg_mod=5,cfg_wraps=2, then start -> count 0,1,2,3,4,0,1,2,3,4,0; tc two pulses;
//    done=1, busy=0 after 2nd wrap; wrap_cnt=2.
// 2. mod=5, pause high 3 cycles at count=2 -> count holds 2, busy=1; resumes 3,4,0.
// 3. cfg_mod=1 then cfg_mod=11 -> cfg_err pulses each time; start -> counts 0..9 (mod 10).
// 4. In RUN, stop and start asserted together -> IDLE, count=0, busy=0, done=0.
// 5. cfg_mod=2,cfg_wraps=0, run 520 cycles -> wrap_cnt rolls 255->0, done never set.
// 6. reset low mid-run at count=3 -> all outputs at reset values before next clk edge;
//    cfg_valid during RUN -> cfg_ready=0, no latch until IDLE/DONE.

Source files
------------

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: run-control sequencer around a programmable modulo counter.
//
// Takes a modulus and a wrap budget over a valid/ready config port. It then
// runs the count from 0 to mod-1, pauses and resumes it, and stops it. It
// reports each wrap and the end of the wrap budget.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cfg_valid  config request; cfg_ready accepts it (IDLE/DONE only)
//   cfg_mod    requested modulus, legal 2..MAX_MOD (else cfg_err pulse)
//   cfg_wraps  wraps before DONE, 0 = run forever
//   start      begin counting from IDLE/DONE
//   pause      level, holds the count in RUN/PAUSE
//   stop       abort to IDLE from any state
//   count      current count, 0..mod-1
//   tc         one-cycle pulse on the edge that wraps the count to 0
//   wrap_cnt   wraps completed since the last start
//   busy       RUN or PAUSE
//   done       DONE
//   cfg_err    one-cycle pulse for an accepted config with an illegal modulus
//
// state | meaning
// IDLE  | stopped, count 0, config accepted
// RUN   | counting on every edge
// PAUSE | count and wrap_cnt held while pause is high
// DONE  | wrap budget reached, count 0, config accepted
module mod_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_MOD = 10,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_mod,
  input  logic [WRAP_W-1:0] cfg_wraps,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [WIDTH-1:0] MAX_MOD_W = WIDTH'(MAX_MOD);
  localparam logic [WIDTH-1:0] MIN_MOD_W = WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mod_q, mod_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              tc_q, tc_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_fire;
  logic              cfg_legal;
  logic [WRAP_W-1:0] wrap_inc;

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign tc        = tc_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign cfg_err   = cfg_err_q;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_mod >= MIN_MOD_W) && (cfg_mod <= MAX_MOD_W);
  assign wrap_inc  = wrap_cnt_q + WRAP_W'(1);

  always_comb begin
    state_d    = state_q;
    mod_d      = mod_q;
    wraps_d    = wraps_q;
    count_d    = count_q;
    wrap_cnt_d = wrap_cnt_q;
    tc_d       = 1'b0;
    cfg_err_d  = 1'b0;

    // Config lands on the same edge as a start, so the run that starts uses it.
    if (cfg_fire) begin
      if (cfg_legal) begin
        mod_d   = cfg_mod;
        wraps_d = cfg_wraps;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (stop) begin
      state_d    = IDLE;
      count_d    = '0;
      wrap_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = RUN;
            count_d    = '0;
            wrap_cnt_d = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count_q == mod_q - WIDTH'(1)) begin
            count_d    = '0;
            tc_d       = 1'b1;
            wrap_cnt_d = wrap_inc;
            if ((wraps_q != '0) && (wrap_inc == wraps_q)) begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mod_q      <= MAX_MOD_W;
      wraps_q    <= '0;
      count_q    <= '0;
      wrap_cnt_q <= '0;
      tc_q       <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      wraps_q    <= wraps_d;
      count_q    <= count_d;
      wrap_cnt_q <= wrap_cnt_d;
      tc_q       <= tc_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_mod;
  logic [7:0] cfg_wraps;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] count;
  logic       tc;
  logic [7:0] wrap_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int checks   = 0;
  int failures = 0;

  mod_counter_ctrl #(.WIDTH(4), .MAX_MOD(10), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mod(cfg_mod), .cfg_wraps(cfg_wraps),
    .start(start), .pause(pause), .stop(stop),
    .count(count), .tc(tc), .wrap_cnt(wrap_cnt),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the run plus plain integer bookkeeping.
  typedef enum {M_STOPPED, M_COUNTING, M_HELD, M_FINISHED} mphase_t;
  mphase_t m_phase;
  int      m_mod, m_wraps, m_count, m_wraps_seen;
  bit      m_tc, m_err;

  task automatic model_reset();
    m_phase = M_STOPPED; m_mod = 10; m_wraps = 0;
    m_count = 0; m_wraps_seen = 0; m_tc = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  old_mod;
    int  old_wraps;
    bit  accepting;
    old_mod   = m_mod;
    old_wraps = m_wraps;
    accepting = (m_phase == M_STOPPED) || (m_phase == M_FINISHED);
    m_tc  = 0;
    m_err = 0;
    if (cfg_valid && accepting) begin
      if (int'(cfg_mod) >= 2 && int'(cfg_mod) <= 10) begin
        m_mod = int'(cfg_mod); m_wraps = int'(cfg_wraps);
      end else m_err = 1;
    end
    if (stop) begin
      m_phase = M_STOPPED; m_count = 0; m_wraps_seen = 0;
    end else if (accepting) begin
      if (start) begin
        m_phase = M_COUNTING; m_count = 0; m_wraps_seen = 0;
      end
    end else if (m_phase == M_COUNTING) begin
      if (pause) m_phase = M_HELD;
      else begin
        m_count = (m_count + 1) % old_mod;
        if (m_count == 0) begin
          m_tc = 1;
          m_wraps_seen = (m_wraps_seen + 1) % 256;
          if (old_wraps != 0 && m_wraps_seen == old_wraps) m_phase = M_FINISHED;
        end
      end
    end else if (m_phase == M_HELD && !pause) begin
      m_phase = M_COUNTING;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"},     32'(count),     32'(m_count));
    chk({tag, ":tc"},        32'(tc),        32'(m_tc));
    chk({tag, ":wrap_cnt"},  32'(wrap_cnt),  32'(m_wraps_seen));
    chk({tag, ":busy"},      32'(busy),      32'(m_phase == M_COUNTING || m_phase == M_HELD));
    chk({tag, ":done"},      32'(done),      32'(m_phase == M_FINISHED));
    chk({tag, ":cfg_err"},   32'(cfg_err),   32'(m_err));
    chk({tag, ":cfg_ready"}, 32'(cfg_ready), 32'(m_phase == M_STOPPED || m_phase == M_FINISHED));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 0; cfg_mod = 0; cfg_wraps = 0;
    start = 0; pause = 0; stop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    tick("idle");

    // Modulus 5, two wraps, then DONE.
    cfg_valid = 1; cfg_mod = 4'd5; cfg_wraps = 8'd2;
    tick("cfg5");
    cfg_valid = 0; start = 1;
    tick("start5");
    start = 0;
    for (int i = 0; i < 13; i++) tick("run5x2");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_wraps", 32'(wrap_cnt), 32'd2);

    // Config together with start, continuous, pause at count 2.
    cfg_valid = 1; cfg_mod = 4'd5; cfg_wraps = 8'd0; start = 1;
    tick("cfgstart");
    cfg_valid = 0; start = 0;
    for (int i = 0; i < 10 && m_count != 2; i++) tick("to2");
    pause = 1;
    for (int i = 0; i < 3; i++) tick("pause");
    chk("t2_hold", 32'(count), 32'd2);
    pause = 0;
    for (int i = 0; i < 5; i++) tick("resume");

    // Illegal moduli, then a run with the default modulus 10 left in place.
    stop = 1; tick("stop"); stop = 0;
    cfg_valid = 1; cfg_mod = 4'd1; tick("cfg1");
    cfg_mod = 4'd11; tick("cfg11");
    cfg_mod = 4'd10; cfg_wraps = 8'd0; tick("cfg10");
    cfg_mod = 4'd0; tick("cfg0");
    cfg_valid = 0; start = 1; tick("start10"); start = 0;
    for (int i = 0; i < 14; i++) tick("run10");

    // stop beats start.
    stop = 1; start = 1; tick("stopstart");
    stop = 0; start = 0;
    for (int i = 0; i < 3; i++) tick("afterstop");

    // Modulus 2, continuous: wrap counter rolls over.
    cfg_valid = 1; cfg_mod = 4'd2; cfg_wraps = 8'd0; start = 1;
    tick("start2");
    cfg_valid = 0; start = 0;
    for (int i = 0; i < 520; i++) tick("roll");
    chk("t5_notdone", 32'(done), 32'd0);

    // Config ignored during RUN, then async reset mid-run.
    stop = 1; tick("stop6"); stop = 0;
    cfg_valid = 1; cfg_mod = 4'd6; cfg_wraps = 8'd0; start = 1; tick("start6");
    start = 0; cfg_mod = 4'd3; cfg_wraps = 8'd1;
    for (int i = 0; i < 12 && m_count != 3; i++) tick("cfg_in_run");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    cfg_valid = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick("post_rst");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_mod   = 4'($urandom_range(0, 15));
      cfg_wraps = 8'($urandom_range(0, 4));
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      pause     = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
